extend_pipe: RTL

Pipelined, parametrised immediate generator for the decode stage. Accepts an instruction immediate field, a format select and a PC over a valid/ready handshake. One cycle later it returns the sign-extended immediate and the PC-relative target (pc + imm). A two-entry skid buffer gives full throughput with a registered in_ready, and the block flags illegal formats instead of silently holding a stale value.

---
 rtl/extend_pkg.sv | 20 ++
 rtl/extend_pipe_if.sv | 28 ++
 rtl/extend_core.sv | 39 +++
 rtl/extend_pipe.sv | 112 +++++++++++
 4 files changed

// File: rtl/extend_pkg.sv
// Shared types for the extend_pipe immediate generator: format encodings and occupancy states.
// Optional build macro EXTEND_ZIMM_EN enables the CSR zimm format (fmt 101).
package extend_pkg;

   typedef logic [2:0] fmt_t;

   localparam fmt_t FMT_I = 3'b000;
   localparam fmt_t FMT_S = 3'b001;
   localparam fmt_t FMT_B = 3'b010;
   localparam fmt_t FMT_U = 3'b011;
   localparam fmt_t FMT_J = 3'b100;
   localparam fmt_t FMT_Z = 3'b101;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } occ_t;

endpackage

// File: rtl/extend_pipe_if.sv
// Handshake bundle for extend_pipe: upstream decode request and downstream result.
interface extend_pipe_if #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 4
);
   logic                    in_valid;
   logic                    in_ready;
   logic [24:0]             in_instr;
   extend_pkg::fmt_t        in_fmt;
   logic [XLEN-1:0]         in_pc;
   logic [TAG_W-1:0]        in_tag;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [XLEN-1:0]  out_imm;
   logic [XLEN-1:0]         out_target;
   logic [TAG_W-1:0]        out_tag;
   logic                    out_illegal;

   modport master (
      output in_valid, in_instr, in_fmt, in_pc, in_tag, out_ready,
      input  in_ready, out_valid, out_imm, out_target, out_tag, out_illegal
   );

   modport slave (
      input  in_valid, in_instr, in_fmt, in_pc, in_tag, out_ready,
      output in_ready, out_valid, out_imm, out_target, out_tag, out_illegal
   );
endinterface

// File: rtl/extend_core.sv
// Combinational immediate decode: builds the sign-extended immediate and pc-relative target.
// Format 101 decodes as CSR zimm only when EXTEND_ZIMM_EN is defined; otherwise it is illegal.
module extend_core
   import extend_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [24:0]            instr,
   input  fmt_t                   fmt,
   input  logic [XLEN-1:0]        pc,
   output logic signed [XLEN-1:0] imm,
   output logic [XLEN-1:0]        target,
   output logic                   illegal
);

   logic signed [31:0] imm32;

   // instr[k] holds instruction bit k+7
   always_comb begin
      imm32   = '0;
      illegal = 1'b0;
      case (fmt)
         FMT_I: imm32 = {{20{instr[24]}}, instr[24:13]};
         FMT_S: imm32 = {{20{instr[24]}}, instr[24:18], instr[4:0]};
         FMT_B: imm32 = {{20{instr[24]}}, instr[0], instr[23:18], instr[4:1], 1'b0};
         FMT_U: imm32 = {instr[24:5], 12'b0};
         FMT_J: imm32 = {{12{instr[24]}}, instr[12:5], instr[13], instr[23:14], 1'b0};
`ifdef EXTEND_ZIMM_EN
         FMT_Z: imm32 = {27'b0, instr[12:8]};
`endif
         default: illegal = 1'b1;
      endcase
   end

   // imm32 is signed, so widening to 64 bits replicates bit 31
   assign imm    = XLEN'(imm32);
   assign target = pc + imm;

endmodule

// File: rtl/extend_pipe.sv
// Immediate generator stage: decode, then a two-entry skid buffer with a registered in_ready.
// Optional build macro EXTEND_ZIMM_EN (handled in extend_core) enables the zimm format.
module extend_pipe
   import extend_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 4
) (
   input logic          clk,
   input logic          reset,
   extend_pipe_if.slave bus
);

   generate
      if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
         $error("extend_pipe: XLEN must be 32 or 64");
      end
   endgenerate

   typedef struct packed {
      logic signed [XLEN-1:0] imm;
      logic [XLEN-1:0]        target;
      logic [TAG_W-1:0]       tag;
      logic                   illegal;
   } entry_t;

   occ_t   state_q, state_d;
   logic   in_ready_q;
   logic   accept, retire;
   logic   load_main, from_skid, load_skid;
   entry_t dec_p0, main_p1, skid_p1;

   // Stage 0: decode ahead of the buffer registers
   extend_core #(.XLEN(XLEN)) u_core (
      .instr   (bus.in_instr),
      .fmt     (bus.in_fmt),
      .pc      (bus.in_pc),
      .imm     (dec_p0.imm),
      .target  (dec_p0.target),
      .illegal (dec_p0.illegal)
   );
   assign dec_p0.tag = bus.in_tag;

   assign accept = bus.in_valid & in_ready_q;
   assign retire = (state_q != ST_EMPTY) & bus.out_ready;

   always_comb begin
      state_d   = state_q;
      load_main = 1'b0;
      from_skid = 1'b0;
      load_skid = 1'b0;
      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               state_d   = ST_ONE;
               load_main = 1'b1;
            end
         end
         ST_ONE: begin
            if (accept && !retire) begin
               state_d   = ST_TWO;
               load_skid = 1'b1;
            end else if (!accept && retire) begin
               state_d = ST_EMPTY;
            end else if (accept && retire) begin
               load_main = 1'b1;
            end
         end
         ST_TWO: begin
            if (retire) begin
               state_d   = ST_ONE;
               load_main = 1'b1;
               from_skid = 1'b1;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d != ST_TWO);
      end
   end

   // Stage 1: main (output) register and skid register
   always_ff @(posedge clk) begin
      if (reset) begin
         main_p1 <= '0;
      end else if (load_main) begin
         main_p1 <= from_skid ? skid_p1 : dec_p0;
      end
   end

   always_ff @(posedge clk) begin
      if (load_skid) begin
         skid_p1 <= dec_p0;
      end
   end

   assign bus.in_ready    = in_ready_q;
   assign bus.out_valid   = (state_q != ST_EMPTY);
   assign bus.out_imm     = main_p1.imm;
   assign bus.out_target  = main_p1.target;
   assign bus.out_tag     = main_p1.tag;
   assign bus.out_illegal = main_p1.illegal;

endmodule
